// File: rtl/seq_comparator.sv
// Bit-serial magnitude comparator: walks the captured operands MSB first,
// one bit per clock, and reports gt/lt/eq with a one-cycle done pulse.
// Supports unsigned and two's-complement operands and an optional early
// exit on the first differing bit.
module seq_comparator #(
    parameter int WIDTH      = 8,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  a_reg, a_next;
    logic [WIDTH-1:0]  b_reg, b_next;
    logic              signed_reg, signed_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic              greater_reg, greater_next;
    logic              less_reg, less_next;
    logic              gt_reg, gt_next;
    logic              lt_reg, lt_next;
    logic              eq_reg, eq_next;

    // Per-bit views of the captured operands: where they differ, and
    // whether A wins at that position. The sign bit's winner is inverted
    // in signed mode, since a set sign bit means a smaller value.
    logic [WIDTH-1:0]  diff_vec;
    logic [WIDTH-1:0]  a_wins_vec;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign diff_vec[gi] = a_reg[gi] ^ b_reg[gi];
            if (gi == WIDTH - 1) begin : g_sign
                assign a_wins_vec[gi] = a_reg[gi] ^ signed_reg;
            end else begin : g_mag
                assign a_wins_vec[gi] = a_reg[gi];
            end
        end
    endgenerate

    logic found_now;
    logic greater_upd;
    logic less_upd;

    // Next-state logic: operand capture on accept, one bit per RUN cycle.
    always_comb begin
        state_next   = state_reg;
        a_next       = a_reg;
        b_next       = b_reg;
        signed_next  = signed_reg;
        idx_next     = idx_reg;
        greater_next = greater_reg;
        less_next    = less_reg;
        gt_next      = gt_reg;
        lt_next      = lt_reg;
        eq_next      = eq_reg;
        found_now    = 1'b0;
        greater_upd  = greater_reg;
        less_upd     = less_reg;

        case (state_reg)
            IDLE, DONE: begin
                if (state_reg == DONE) begin
                    state_next = IDLE;
                end
                if (start) begin
                    a_next       = A;
                    b_next       = B;
                    signed_next  = signed_mode;
                    idx_next     = IDX_MSB;
                    greater_next = 1'b0;
                    less_next    = 1'b0;
                    state_next   = RUN;
                end
            end
            RUN: begin
                // Only the first differing bit decides; flags are sticky.
                if (diff_vec[idx_reg] && !greater_reg && !less_reg) begin
                    found_now   = 1'b1;
                    greater_upd = a_wins_vec[idx_reg];
                    less_upd    = !a_wins_vec[idx_reg];
                end
                greater_next = greater_upd;
                less_next    = less_upd;
                if (idx_reg == '0 || (EARLY_EXIT != 0 && found_now)) begin
                    state_next = DONE;
                    gt_next    = greater_upd;
                    lt_next    = less_upd;
                    eq_next    = !(greater_upd || less_upd);
                end else begin
                    idx_next = idx_reg - IDX_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and result registers; reset overrides any comparison in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            signed_reg  <= 1'b0;
            idx_reg     <= IDX_MSB;
            greater_reg <= 1'b0;
            less_reg    <= 1'b0;
            gt_reg      <= 1'b0;
            lt_reg      <= 1'b0;
            eq_reg      <= 1'b1;
        end else begin
            state_reg   <= state_next;
            a_reg       <= a_next;
            b_reg       <= b_next;
            signed_reg  <= signed_next;
            idx_reg     <= idx_next;
            greater_reg <= greater_next;
            less_reg    <= less_next;
            gt_reg      <= gt_next;
            lt_reg      <= lt_next;
            eq_reg      <= eq_next;
        end
    end

    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);
    assign gt   = gt_reg;
    assign lt   = lt_reg;
    assign eq   = eq_reg;

endmodule

// File: tb/tb_seq_comparator.sv
// Directed and randomized checks for seq_comparator: two 8-bit instances
// (full scan and early exit) share stimulus; a 32-bit early-exit instance
// runs randomized trials against a behavioural model.
module tb_seq_comparator;

    localparam logic [2:0] R_GT = 3'b100;
    localparam logic [2:0] R_LT = 3'b010;
    localparam logic [2:0] R_EQ = 3'b001;

    logic clk;
    logic reset;

    logic       start8, sgn8;
    logic [7:0] a8, b8;
    logic       busy_e0, done_e0, gt_e0, lt_e0, eq_e0;
    logic       busy_e1, done_e1, gt_e1, lt_e1, eq_e1;

    logic        start32, sgn32;
    logic [31:0] a32, b32;
    logic        busy_w, done_w, gt_w, lt_w, eq_w;

    int checks = 0;
    int passes = 0;

    seq_comparator #(.WIDTH(8), .EARLY_EXIT(0)) u_e0 (
        .clk(clk), .reset(reset), .start(start8), .signed_mode(sgn8),
        .A(a8), .B(b8), .busy(busy_e0), .done(done_e0),
        .gt(gt_e0), .lt(lt_e0), .eq(eq_e0)
    );

    seq_comparator #(.WIDTH(8), .EARLY_EXIT(1)) u_e1 (
        .clk(clk), .reset(reset), .start(start8), .signed_mode(sgn8),
        .A(a8), .B(b8), .busy(busy_e1), .done(done_e1),
        .gt(gt_e1), .lt(lt_e1), .eq(eq_e1)
    );

    seq_comparator #(.WIDTH(32), .EARLY_EXIT(1)) u_w32 (
        .clk(clk), .reset(reset), .start(start32), .signed_mode(sgn32),
        .A(a32), .B(b32), .busy(busy_w), .done(done_w),
        .gt(gt_w), .lt(lt_w), .eq(eq_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sgn;
        logic [2:0] res;
        int         k1;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One comparison on both 8-bit instances; tracks done cycle, busy count, result.
    task automatic run8(input vec_t v, input int n);
        int lat0, lat1, bcnt0, bcnt1;
        logic [2:0] res0, res1;
        logic overlap;
        lat0 = 0; lat1 = 0; bcnt0 = 0; bcnt1 = 0;
        res0 = '0; res1 = '0; overlap = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        a8 = v.a; b8 = v.b; sgn8 = v.sgn; start8 = 1'b1;
        step();
        start8 = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (busy_e0) bcnt0++;
            if (busy_e1) bcnt1++;
            if (done_e0 && lat0 == 0) begin lat0 = c; res0 = {gt_e0, lt_e0, eq_e0}; end
            if (done_e1 && lat1 == 0) begin lat1 = c; res1 = {gt_e1, lt_e1, eq_e1}; end
            if ((busy_e0 && done_e0) || (busy_e1 && done_e1)) overlap = 1'b1;
            step();
        end
        $display("vec %0d: A=%02h B=%02h s=%0d -> e0 done@%0d res=%03b, e1 done@%0d res=%03b",
                 n, v.a, v.b, v.sgn, lat0, res0, lat1, res1);
        check($sformatf("v%0d_lat_e0", n), lat0, 9);
        check($sformatf("v%0d_lat_e1", n), lat1, v.k1 + 1);
        check($sformatf("v%0d_busy_e0", n), bcnt0, 8);
        check($sformatf("v%0d_busy_e1", n), bcnt1, v.k1);
        check($sformatf("v%0d_res_e0", n), res0, v.res);
        check($sformatf("v%0d_res_e1", n), res1, v.res);
        check($sformatf("v%0d_hold_e0", n), {gt_e0, lt_e0, eq_e0}, v.res);
        check($sformatf("v%0d_overlap", n), overlap, 1'b0);
    endtask

    initial begin
        int lat, k, saw_done;
        logic [2:0] res, exp_res;
        logic [31:0] ra, rb;
        logic rs;

        vecs[0] = '{8'h80, 8'h7F, 1'b0, R_GT, 1};
        vecs[1] = '{8'h80, 8'h7F, 1'b1, R_LT, 1};
        vecs[2] = '{8'h5A, 8'h5A, 1'b0, R_EQ, 8};
        vecs[3] = '{8'h00, 8'hFF, 1'b0, R_LT, 1};
        vecs[4] = '{8'h00, 8'hFF, 1'b1, R_GT, 1};
        vecs[5] = '{8'h12, 8'h13, 1'b0, R_LT, 8};
        vecs[6] = '{8'hF0, 8'hE0, 1'b1, R_GT, 4};
        vecs[7] = '{8'h7F, 8'h7E, 1'b1, R_GT, 8};
        vecs[8] = '{8'h3C, 8'h5C, 1'b0, R_LT, 2};
        vecs[9] = '{8'hFF, 8'hFF, 1'b1, R_EQ, 8};

        reset = 1'b1; start8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
        start32 = 1'b0; sgn32 = 1'b0; a32 = '0; b32 = '0;

        // Reset state; start is also held high to show reset wins.
        @(posedge clk); start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        $display("reset: e0 %b%b %03b e1 %b%b %03b w %b%b %03b",
                 busy_e0, done_e0, {gt_e0, lt_e0, eq_e0},
                 busy_e1, done_e1, {gt_e1, lt_e1, eq_e1},
                 busy_w, done_w, {gt_w, lt_w, eq_w});
        check("rst_e0", {busy_e0, done_e0, gt_e0, lt_e0, eq_e0}, 5'b00001);
        check("rst_e1", {busy_e1, done_e1, gt_e1, lt_e1, eq_e1}, 5'b00001);
        check("rst_w32", {busy_w, done_w, gt_w, lt_w, eq_w}, 5'b00001);
        start8 = 1'b0;

        // Table vectors; the first one starts on the first edge with reset low.
        for (int i = 0; i < 10; i++) run8(vecs[i], i);

        // Back-to-back: 5A/5A, then 01/02 started in the DONE cycle.
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h5A; sgn8 = 1'b0; start8 = 1'b1;
        step();
        start8 = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            if (c == 9) begin
                $display("b2b c9: done e0=%0d e1=%0d eq e0=%0d e1=%0d", done_e0, done_e1, eq_e0, eq_e1);
                check("b2b_done9_e0", {done_e0, eq_e0}, 2'b11);
                check("b2b_done9_e1", {done_e1, eq_e1}, 2'b11);
                a8 = 8'h01; b8 = 8'h02; start8 = 1'b1;
            end
            if (c == 10) begin
                start8 = 1'b0;
                $display("b2b c10: busy e0=%0d e1=%0d res e0=%03b", busy_e0, busy_e1, {gt_e0, lt_e0, eq_e0});
                check("b2b_busy10_e0", {busy_e0, gt_e0, lt_e0, eq_e0}, 4'b1001);
                check("b2b_busy10_e1", {busy_e1, gt_e1, lt_e1, eq_e1}, 4'b1001);
            end
            if (c == 16) check("b2b_hold16_e1", {done_e1, eq_e1}, 2'b01);
            if (c == 17) begin
                $display("b2b c17: e1 done=%0d res=%03b", done_e1, {gt_e1, lt_e1, eq_e1});
                check("b2b_done17_e1", {done_e1, gt_e1, lt_e1, eq_e1}, 4'b1010);
                check("b2b_run17_e0", {busy_e0, eq_e0}, 2'b11);
            end
            if (c == 18) begin
                $display("b2b c18: e0 done=%0d res=%03b", done_e0, {gt_e0, lt_e0, eq_e0});
                check("b2b_done18_e0", {done_e0, gt_e0, lt_e0, eq_e0}, 4'b1010);
            end
            step();
        end

        // Start and operand changes during RUN are ignored.
        @(negedge clk);
        a8 = 8'h00; b8 = 8'hFF; sgn8 = 1'b0; start8 = 1'b1;
        step();
        start8 = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (c == 1) begin
                start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00;
            end
            if (c == 2) begin
                start8 = 1'b0;
                $display("midrun c2: e1 done=%0d res=%03b", done_e1, {gt_e1, lt_e1, eq_e1});
                check("mid_done2_e1", {done_e1, gt_e1, lt_e1, eq_e1}, 4'b1010);
            end
            if (c == 3) check("mid_idle3_e1", busy_e1, 1'b0);
            if (c == 9) begin
                $display("midrun c9: e0 done=%0d res=%03b", done_e0, {gt_e0, lt_e0, eq_e0});
                check("mid_done9_e0", {done_e0, gt_e0, lt_e0, eq_e0}, 4'b1010);
            end
            if (c == 10) check("mid_idle10_e0", busy_e0, 1'b0);
            step();
        end

        // Reset during RUN: cleared next cycle, no done afterwards.
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h13; sgn8 = 1'b0; start8 = 1'b1;
        step();
        start8 = 1'b0;
        saw_done = 0;
        for (int c = 1; c <= 16; c++) begin
            if (c == 4) begin
                check("rr_busy4", {busy_e0, busy_e1}, 2'b11);
                reset = 1'b1;
            end
            if (c == 5) begin
                reset = 1'b0;
                $display("rr c5: e0 %b%b %03b e1 %b%b %03b", busy_e0, done_e0, {gt_e0, lt_e0, eq_e0},
                         busy_e1, done_e1, {gt_e1, lt_e1, eq_e1});
                check("rr_c5_e0", {busy_e0, done_e0, gt_e0, lt_e0, eq_e0}, 5'b00001);
                check("rr_c5_e1", {busy_e1, done_e1, gt_e1, lt_e1, eq_e1}, 5'b00001);
            end
            if (c >= 5 && (done_e0 || done_e1 || busy_e0 || busy_e1)) saw_done = 1;
            step();
        end
        check("rr_no_done", saw_done, 0);

        // 32-bit randomized trials against a behavioural model.
        for (int t = 0; t < 1000; t++) begin
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0: ra = $urandom;
                1: ra = rb;
                default: ra = rb ^ (32'd1 << $urandom_range(0, 31));
            endcase
            if (rs ? ($signed(ra) > $signed(rb)) : (ra > rb)) exp_res = R_GT;
            else if (ra == rb) exp_res = R_EQ;
            else exp_res = R_LT;
            k = 32;
            for (int i = 31; i >= 0; i--) begin
                if (ra[i] != rb[i]) begin
                    k = 32 - i;
                    break;
                end
            end
            @(negedge clk);
            a32 = ra; b32 = rb; sgn32 = rs; start32 = 1'b1;
            step();
            start32 = 1'b0;
            lat = 0; res = '0;
            for (int c = 1; c <= 40; c++) begin
                if (done_w) begin
                    lat = c;
                    res = {gt_w, lt_w, eq_w};
                    break;
                end
                step();
            end
            $display("w32 %0d: A=%08h B=%08h s=%0d done@%0d res=%03b", t, ra, rb, rs, lat, res);
            check($sformatf("w32_%0d_lat", t), lat, k + 1);
            check($sformatf("w32_%0d_res", t), res, exp_res);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
